// File: rtl/mm_riot_gen.sv
// mm_riot_gen: parametrised RAM / I/O / timer block for a CPU data bus.
//
// Provides 2**RAM_AW words of RAM, NPORT bidirectional ports with data
// and direction registers, a prescaled down-counting timer with one-shot
// and auto-reload modes, and an edge detector on one port-0 pin. Both the
// timer and the edge detector can raise the active-low interrupt.
//
// Ports:
//   CLK       clock
//   RES       synchronous active-high reset
//   CS        chip select, active high
//   R_W       1 = read, 0 = write
//   RS_N      0 = RAM access, 1 = register access
//   A         address (RAM_AW bits; register decode uses A[4:0])
//   D_IN      write data
//   D_OUT     read data (combinational, 0 when not reading)
//   PORT_IN   pin inputs, port i at [i*DW +: DW]
//   PORT_OUT  data registers, port i at [i*DW +: DW]
//   PORT_DIR  direction registers, 1 = output
//   IRQ_N     interrupt request, active low
module mm_riot_gen #(
    parameter int DW       = 8,
    parameter int RAM_AW   = 7,
    parameter int NPORT    = 2,
    parameter int EDGE_BIT = 7
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  CS,
    input  logic                  R_W,
    input  logic                  RS_N,
    input  logic [RAM_AW-1:0]     A,
    input  logic [DW-1:0]         D_IN,
    output logic [DW-1:0]         D_OUT,
    input  logic [NPORT*DW-1:0]   PORT_IN,
    output logic [NPORT*DW-1:0]   PORT_OUT,
    output logic [NPORT*DW-1:0]   PORT_DIR,
    output logic                  IRQ_N
);

    localparam int PW = 11;

    // Prescale divisor for a 2-bit select code; 1024 needs 11 bits.
    function automatic logic [PW-1:0] presc_val(input logic [1:0] sel);
        logic [PW-1:0] val;
        case (sel)
            2'b00:   val = 11'd1;
            2'b01:   val = 11'd8;
            2'b10:   val = 11'd64;
            default: val = 11'd1024;
        endcase
        return val;
    endfunction

    logic [DW-1:0]  mem_q [2**RAM_AW];

    logic [DW-1:0]  dr_q  [NPORT];
    logic [DW-1:0]  dr_d  [NPORT];
    logic [DW-1:0]  ddr_q [NPORT];
    logic [DW-1:0]  ddr_d [NPORT];

    logic [DW-1:0]  timer_q, timer_d;
    logic [DW-1:0]  reload_q, reload_d;
    logic [1:0]     presc_sel_q, presc_sel_d;
    logic [PW-1:0]  presc_cnt_q, presc_cnt_d;
    logic           auto_q, auto_d;
    logic           tim_ie_q, tim_ie_d;
    logic           tim_flag_q, tim_flag_d;
    logic           edge_ie_q, edge_ie_d;
    logic           edge_pol_q, edge_pol_d;
    logic           edge_flag_q, edge_flag_d;
    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           prev_q, prev_d;
    logic           irq_n_q, irq_n_d;

    logic           wr_s;
    logic           rd_s;
    logic [1:0]     port_idx_s;
    logic           tick_s;
    logic           edge_evt_s;
    logic           pin_s;
    logic [DW-1:0]  port_rd_s;
    logic [DW-1:0]  flag_rd_s;

    assign wr_s       = CS & ~R_W;
    assign rd_s       = CS & R_W;
    assign port_idx_s = A[2:1];
    assign IRQ_N      = irq_n_q;

    // Drive the flattened port buses from the per-port registers.
    always_comb begin
        PORT_OUT = {(NPORT*DW){1'b0}};
        PORT_DIR = {(NPORT*DW){1'b0}};
        for (int i = 0; i < NPORT; i++) begin
            PORT_OUT[i*DW +: DW] = dr_q[i];
            PORT_DIR[i*DW +: DW] = ddr_q[i];
        end
    end

    // Watched pin: the driven value when configured as output, else the pad.
    always_comb begin
        if (ddr_q[0][EDGE_BIT]) begin
            pin_s = dr_q[0][EDGE_BIT];
        end else begin
            pin_s = PORT_IN[EDGE_BIT];
        end
    end

    // Read-side values for port and flag registers.
    always_comb begin
        port_rd_s = {DW{1'b0}};
        for (int i = 0; i < NPORT; i++) begin
            // Unmatched indices (including idx >= NPORT) contribute zero.
            port_rd_s = port_rd_s | ((port_idx_s == 2'(i)) ?
                (A[0] ? ddr_q[i]
                      : ((PORT_IN[i*DW +: DW] & ~ddr_q[i]) | (dr_q[i] & ddr_q[i])))
                : {DW{1'b0}});
        end
        flag_rd_s         = {DW{1'b0}};
        flag_rd_s[DW-1]   = tim_flag_q;
        flag_rd_s[DW-2]   = edge_flag_q;
    end

    // Combinational read data mux.
    always_comb begin
        D_OUT = {DW{1'b0}};
        if (!rd_s) begin
            D_OUT = {DW{1'b0}};
        end else if (!RS_N) begin
            D_OUT = mem_q[A];
        end else if (A[4]) begin
            D_OUT = A[0] ? flag_rd_s : timer_q;
        end else if (!A[3]) begin
            D_OUT = port_rd_s;
        end else begin
            D_OUT = {DW{1'b0}};
        end
    end

    // Next-state logic: free-running timer and edge detector first, bus accesses override.
    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            dr_d[i]  = dr_q[i];
            ddr_d[i] = ddr_q[i];
        end
        timer_d     = timer_q;
        reload_d    = reload_q;
        presc_sel_d = presc_sel_q;
        presc_cnt_d = presc_cnt_q;
        auto_d      = auto_q;
        tim_ie_d    = tim_ie_q;
        tim_flag_d  = tim_flag_q;
        edge_ie_d   = edge_ie_q;
        edge_pol_d  = edge_pol_q;
        edge_flag_d = edge_flag_q;

        // Prescaler counts down to zero; the edge on which it is zero is the tick.
        tick_s = (presc_cnt_q == {PW{1'b0}});
        if (tick_s) begin
            if (timer_q == {DW{1'b0}}) begin
                tim_flag_d = 1'b1;
                if (auto_q) begin
                    timer_d     = reload_q;
                    presc_cnt_d = presc_val(presc_sel_q) - 11'd1;
                end else begin
                    // One-shot: keep running at full clock rate after expiry.
                    timer_d     = {DW{1'b1}};
                    presc_sel_d = 2'b00;
                    presc_cnt_d = {PW{1'b0}};
                end
            end else begin
                timer_d     = timer_q - {{(DW-1){1'b0}}, 1'b1};
                presc_cnt_d = presc_val(presc_sel_q) - 11'd1;
            end
        end else begin
            presc_cnt_d = presc_cnt_q - 11'd1;
        end

        sync1_d    = pin_s;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        edge_evt_s = edge_pol_q ? (sync2_q & ~prev_q) : (~sync2_q & prev_q);
        if (edge_evt_s) begin
            edge_flag_d = 1'b1;
        end else begin
            edge_flag_d = edge_flag_q;
        end

        if (wr_s && RS_N) begin
            case (A[4:3])
                2'b00: begin
                    for (int i = 0; i < NPORT; i++) begin
                        dr_d[i]  = ((port_idx_s == 2'(i)) && !A[0]) ? D_IN : dr_q[i];
                        ddr_d[i] = ((port_idx_s == 2'(i)) &&  A[0]) ? D_IN : ddr_q[i];
                    end
                end
                2'b01: begin
                    edge_pol_d = A[0];
                    edge_ie_d  = A[1];
                end
                default: begin
                    // Timer load wins over any underflow on the same edge.
                    timer_d     = D_IN;
                    reload_d    = D_IN;
                    presc_sel_d = A[1:0];
                    presc_cnt_d = presc_val(A[1:0]);
                    auto_d      = A[2];
                    tim_ie_d    = A[3];
                    tim_flag_d  = 1'b0;
                end
            endcase
        end else if (rd_s && RS_N && A[4]) begin
            if (A[0]) begin
                // A coincident edge event keeps the flag set.
                edge_flag_d = edge_evt_s;
            end else begin
                tim_ie_d   = A[3];
                tim_flag_d = 1'b0;
            end
        end else begin
            tim_flag_d = tim_flag_d;
        end

        // IRQ follows the next-state flags so the registered output adds no latency.
        irq_n_d = ~((tim_flag_d & tim_ie_d) | (edge_flag_d & edge_ie_d));
    end

    // Register state with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int i = 0; i < NPORT; i++) begin
                dr_q[i]  <= {DW{1'b0}};
                ddr_q[i] <= {DW{1'b0}};
            end
            timer_q     <= {DW{1'b1}};
            reload_q    <= {DW{1'b0}};
            presc_sel_q <= 2'b11;
            presc_cnt_q <= 11'd1024;
            auto_q      <= 1'b0;
            tim_ie_q    <= 1'b0;
            tim_flag_q  <= 1'b0;
            edge_ie_q   <= 1'b0;
            edge_pol_q  <= 1'b0;
            edge_flag_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            irq_n_q     <= 1'b1;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                dr_q[i]  <= dr_d[i];
                ddr_q[i] <= ddr_d[i];
            end
            timer_q     <= timer_d;
            reload_q    <= reload_d;
            presc_sel_q <= presc_sel_d;
            presc_cnt_q <= presc_cnt_d;
            auto_q      <= auto_d;
            tim_ie_q    <= tim_ie_d;
            tim_flag_q  <= tim_flag_d;
            edge_ie_q   <= edge_ie_d;
            edge_pol_q  <= edge_pol_d;
            edge_flag_q <= edge_flag_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            irq_n_q     <= irq_n_d;
        end
    end

    // RAM write port; contents survive reset but writes are blocked while RES is high.
    always_ff @(posedge CLK) begin
        if (wr_s && !RS_N && !RES) begin
            mem_q[A] <= D_IN;
        end
    end

endmodule

// File: doc/mm_riot_gen.md
Name: mm_riot_gen

Overview:
- Parametrised RAM-I/O-timer: RAM depth, port count and data width are configurable.
- Timer supports one-shot and auto-reload modes.
- Edge-detect interrupt has a 2-flop synchroniser.
- Sits on the CPU data bus in the same place as the fixed 128x8 RIOT, and drives peripheral pins plus IRQ_N.

Parameters:
DW, 8, data/port/timer width in bits (8..16)
RAM_AW, 7, RAM address width; RAM depth = 2**RAM_AW; also the width of A (must be >= 5)
NPORT, 2, number of bidirectional ports (1..4)
EDGE_BIT, 7, bit of port 0 watched by the edge detector

Ports:
CLK  in  1  clock
RES  in  1  synchronous active-high reset
CS  in  1  chip select, active high
R_W  in  1  1 = read, 0 = write
RS_N  in  1  0 = RAM access, 1 = register access
A  in  RAM_AW  address
D_IN  in  DW  write data
D_OUT  out  DW  read data
PORT_IN  in  NPORT*DW  pin inputs; port i occupies [i*DW +: DW]
PORT_OUT  out  NPORT*DW  data registers
PORT_DIR  out  NPORT*DW  DDRs; 1 = output
IRQ_N  out  1  interrupt, active low

Behaviour:
- Clock and reset: one clock CLK. RES is synchronous and active-high.
- Reset values:
  - All DR and DDR = 0, so PORT_OUT = 0 and PORT_DIR = 0.
  - Timer = all ones, prescale = 1024, auto-reload = 0, reload value = 0.
  - tim_flag, edge_flag, tim_ie, edge_ie, edge_pol = 0; synchroniser flops = 0.
  - IRQ_N = 1.
  - RAM contents are not reset.
- Access qualification: wr = CS & !R_W, sampled at posedge CLK. rd = CS & R_W.
- Read data: D_OUT is combinational and equals 0 when !rd.
- RAM (RS_N = 0):
  - Write is synchronous on wr.
  - Read is asynchronous: D_OUT = mem[A].
- Register map (RS_N = 1), decoded on A[4:3]:
  - A[4:3] = 00, port registers. idx = A[2:1]; A[0] = 0 selects DR, 1 selects DDR.
    - Port read returns (PORT_IN & ~DDR) | (DR & DDR); DDR read returns DDR.
    - idx >= NPORT reads 0 and ignores writes.
  - A[4:3] = 01, write: edge control.
    - edge_pol <= A[0] (0 = falling, 1 = rising); edge_ie <= A[1].
    - Read at this address returns 0.
  - A[4] = 1, write: timer load.
    - timer <= D_IN and reload <= D_IN.
    - Prescale <= {1, 8, 64, 1024}[A[1:0]]; auto-reload <= A[2]; tim_ie <= A[3].
    - Prescaler counter restarts; tim_flag <= 0.
  - A[4] = 1, read, A[0] = 0: D_OUT = timer.
    - tim_ie <= A[3]; tim_flag <= 0.
  - A[4] = 1, read, A[0] = 1: D_OUT = {tim_flag, edge_flag, zeros}.
    - edge_flag <= 0; tim_flag unaffected.
- Timer timing:
  - A load at edge t holds value N for edges t+1..t+P; the value reads N-1 after edge t+P+1. P = prescale.
  - A tick occurs when the prescaler counter wraps.
- Underflow (tick while timer = 0):
  - One-shot mode: timer <= all ones, tim_flag <= 1, and prescale forced to 1 until the next load. The timer keeps decrementing each clock and wraps freely; the flag stays set.
  - Auto-reload mode: timer <= reload, prescale kept, tim_flag <= 1.
  - Reload = 0 in auto-reload mode: flag is set on every tick.
- Edge detect:
  - Pin value = DDR[EDGE_BIT] ? DR[EDGE_BIT] : PORT_IN[EDGE_BIT] of port 0.
  - The pin passes through 2 synchroniser flops plus a previous-value flop.
  - An edge of the selected polarity sets edge_flag 3 clocks after the pin change.
- Simultaneous events:
  - Timer write/read on the same edge as underflow: the access wins, flag ends 0.
  - Flag-register read on the same edge as an edge event: edge_flag ends 1.
  - RES dominates every access.
  - Reset mid-count aborts the count; the timer reads all ones next cycle.
- Interrupt: IRQ_N = !((tim_flag & tim_ie) | (edge_flag & edge_ie)), registered-flag based, with no extra latency beyond the flags.

Test Plan:
1. Reset, then read every DR/DDR and the flag register -> all read 0; IRQ_N = 1; PORT_DIR = 0.
2. DDR0 = 0xF0, DR0 = 0xA5, PORT_IN port 0 = 0x3C -> DR0 read returns 0xAC; PORT_OUT[7:0] = 0xA5. Access to idx 3 with NPORT = 2 returns 0.
3. Write timer 0x03 at A = 0x19 (prescale 8, tim_ie = 1):
   - Value 3 for 8 cycles, then 2, 1, 0.
   - Underflow after 32 cycles: timer = 0xFF, tim_flag = 1, IRQ_N = 0.
   - The following cycles read 0xFE, 0xFD.
   - A timer read clears the flag and IRQ_N returns to 1.
4. Auto-reload: write 0x02 at A = 0x14 (prescale 1) -> flag sets every 3 cycles and the timer sequence is 2, 1, 0, 2. A timer write on the underflow edge leaves the flag at 0.
5. Edge: write A = 0x0B (rising, enabled), DDR0 = 0, toggle PORT_IN[7] 0->1 -> edge_flag = 1 three clocks later, IRQ_N = 0. A falling edge does not set it. A flag read clears it; a flag read coincident with a new edge leaves it at 1.
6. RAM: write 0x5A to address 0x7F with RS_N = 0, then assert RES -> read returns 0x5A while the registers are cleared. Assert RES during a timer count -> timer = 0xFF and flags = 0 on the next cycle.
